instr_sequencer: RTL and testbench

Fetch/issue sequencer that reads 8-bit instruction words from a synchronous program memory and issues the opcode, with register selects, to the control unit under a valid/ready handshake. It is the producer side of the control-unit opcode interface: it generates the same 3-bit opcode stream (000 add … 111 compare) that the control unit decodes into `alu_sel`. It sits between program memory and the control unit / execute stage of the 8-bit CPU.

---
 rtl/instr_sequencer.sv | 137 +++++++++++++
 tb/tb_instr_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue sequencer between program memory and the
// control unit. Each instruction word is fetched from a synchronous memory,
// captured into the instruction register and offered to the execute stage
// under a valid/ready handshake.
// Word format: [7:5] opcode, [4:3] rd, [2:1] rs, [0] last.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds the step input and a PAUSE
// state entered after every non-last handshake.
module instr_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    output logic [2:0]        opcode,
    output logic [1:0]        rd_sel,
    output logic [1:0]        rs_sel,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic              step
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
`ifdef SEQ_SINGLE_STEP_EN
        ,
        S_PAUSE
`endif
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [2:0]        opcode_q;
    logic [1:0]        rd_q;
    logic [1:0]        rs_q;
    logic              last_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    // Next fetch address; wraps silently at the top of the memory.
    assign pc_d = pc_q + ADDR_W'(1);

    // Sequencer FSM; every output is a register so the execute stage sees
    // glitch-free handshake and select signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Address is presented this cycle; data returns next cycle.
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Selects change only here so they hold their last issued
                    // value in every other state.
                    opcode_q <= imem_rdata[7:5];
                    rd_q     <= imem_rdata[4:3];
                    rs_q     <= imem_rdata[2:1];
                    last_q   <= imem_rdata[0];
                    valid_q  <= 1'b1;
                    state_q  <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Valid stays up until the execute stage takes the word.
                    if (issue_ready) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            pc_q    <= pc_d;
`ifdef SEQ_SINGLE_STEP_EN
                            state_q <= S_PAUSE;
`else
                            state_q <= S_FETCH;
`endif
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state_q <= S_FETCH;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = opcode_q;
    assign rd_sel      = rd_q;
    assign rs_sel      = rs_q;
    assign issue_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: table-driven program run with a scoreboard
// of expected issues, plus hand-written timing, backpressure, wrap, ignored
// start, asynchronous reset and (when compiled in) single-step sequences.
module tb_instr_sequencer;

    localparam int AW = 4;
`ifdef SEQ_SINGLE_STEP_EN
    localparam int GAP = 4;   // ISSUE -> PAUSE -> FETCH -> WAIT -> ISSUE
`else
    localparam int GAP = 3;   // ISSUE -> FETCH -> WAIT -> ISSUE
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          issue_ready = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [7:0]    imem_rdata;
    logic [2:0]    opcode;
    logic [1:0]    rd_sel, rs_sel;
    logic          issue_valid, busy, done;
    logic [AW-1:0] pc;
    logic [7:0]    mem [16];

    logic          w_start = 1'b0;
    logic          w_ready = 1'b0;
    logic [1:0]    w_addr, w_pc;
    logic [7:0]    w_rdata;
    logic [2:0]    w_opcode;
    logic [1:0]    w_rd, w_rs;
    logic          w_valid, w_busy, w_done;
    logic [7:0]    wmem [4];

`ifdef SEQ_SINGLE_STEP_EN
    logic          step = 1'b1;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];
    always @(posedge clk) w_rdata <= wmem[w_addr];

    instr_sequencer #(.ADDR_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .opcode(opcode), .rd_sel(rd_sel), .rs_sel(rs_sel),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .busy(busy), .done(done), .pc(pc)
`ifdef SEQ_SINGLE_STEP_EN
        , .step(step)
`endif
    );

    instr_sequencer #(.ADDR_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start),
        .imem_addr(w_addr), .imem_rdata(w_rdata),
        .opcode(w_opcode), .rd_sel(w_rd), .rs_sel(w_rs),
        .issue_valid(w_valid), .issue_ready(w_ready),
        .busy(w_busy), .done(w_done), .pc(w_pc)
`ifdef SEQ_SINGLE_STEP_EN
        , .step(step)
`endif
    );

    typedef struct {
        logic [2:0]    op;
        logic [1:0]    rd;
        logic [1:0]    rs;
        logic [AW-1:0] pc;
    } exp_t;

    typedef struct {
        logic [7:0] word;
        int         delay;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!issue_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        if (!issue_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: issue_valid still 0 after %0d cycles, want 1", cnt);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_short;
        mem[0] = 8'h00;
        mem[1] = 8'h2A;
        mem[2] = 8'hE1;
    endtask

    // Scoreboard: every accepted issue must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_issue: opcode %0h at pc %0h, want no issue", opcode, pc);
            end else begin
                mon_e = sb.pop_front();
                check("issue_opcode", 32'(opcode), 32'(mon_e.op));
                check("issue_rd", 32'(rd_sel), 32'(mon_e.rd));
                check("issue_rs", 32'(rs_sel), 32'(mon_e.rs));
                check("issue_pc", 32'(pc), 32'(mon_e.pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int seen;
        logic [1:0] wrap_pc [5];
        logic [2:0] wrap_op [5];

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        wmem[0] = 8'h00; wmem[1] = 8'h20; wmem[2] = 8'h40; wmem[3] = 8'h60;
        wrap_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        wrap_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

        vt[0] = '{8'h00, 0, 3'b000, 2'd0, 2'd0};
        vt[1] = '{8'h2A, 5, 3'b001, 2'd1, 2'd1};
        vt[2] = '{8'h5E, 1, 3'b010, 2'd3, 2'd3};
        vt[3] = '{8'h94, 0, 3'b100, 2'd2, 2'd2};
        vt[4] = '{8'hB2, 2, 3'b101, 2'd2, 2'd1};
        vt[5] = '{8'hE1, 0, 3'b111, 2'd0, 2'd0};

        // Reset state
        #2;
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_rd", 32'(rd_sel), 0);
        check("rst_rs", 32'(rs_sel), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reference timeline: start in cycle 0, ready held high
        load_short();
        sb.push_back('{3'b000, 2'd0, 2'd0, 4'd0});
        sb.push_back('{3'b001, 2'd1, 2'd1, 4'd1});
        sb.push_back('{3'b111, 2'd0, 2'd0, 4'd2});
        issue_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 3 + 2 * GAP + 2; c++) begin
            check("t1_valid", 32'(issue_valid),
                  32'((c == 3) || (c == 3 + GAP) || (c == 3 + 2 * GAP)));
            check("t1_done", 32'(done), 32'(c == 3 + 2 * GAP + 1));
            check("t1_busy", 32'(busy), 32'(c <= 3 + 2 * GAP + 1));
            tick();
        end
        check("t1_sb_empty", 32'(sb.size()), 0);

        // Table-driven program with per-instruction backpressure
        issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem[i] = vt[i].word;
            sb.push_back('{vt[i].op, vt[i].rd, vt[i].rs, 4'(i)});
        end
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            wait_valid(cnt);
            if (i > 0) check("t2_gap", 32'(cnt), 32'(GAP - 1));
            for (int d = 0; d < vt[i].delay; d++) begin
                check("t2_hold_valid", 32'(issue_valid), 1);
                check("t2_hold_op", 32'(opcode), 32'(vt[i].op));
                check("t2_hold_pc", 32'(pc), 32'(i));
                tick();
            end
            issue_ready = 1'b1;
            tick();
            issue_ready = 1'b0;
            if (i < 5) begin
                check("t2_next_addr", 32'(imem_addr), 32'(i + 1));
                check("t2_valid_drop", 32'(issue_valid), 0);
            end else begin
                check("t2_done", 32'(done), 1);
                check("t2_last_pc", 32'(pc), 5);
                tick();
                check("t2_done_pulse", 32'(done), 0);
                check("t2_idle_busy", 32'(busy), 0);
            end
        end
        check("t2_sb_empty", 32'(sb.size()), 0);

        // start during ISSUE must be ignored
        load_short();
        sb.push_back('{3'b000, 2'd0, 2'd0, 4'd0});
        sb.push_back('{3'b001, 2'd1, 2'd1, 4'd1});
        sb.push_back('{3'b111, 2'd0, 2'd0, 4'd2});
        pulse_start();
        wait_valid(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_valid_kept", 32'(issue_valid), 1);
        check("t3_pc_kept", 32'(pc), 0);
        issue_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            if (done) seen = 1;
            tick();
        end
        check("t3_done_seen", 32'(seen), 1);
        for (int k = 0; k < 6; k++) begin
            check("t3_no_restart", 32'(busy), 0);
            tick();
        end
        check("t3_sb_empty", 32'(sb.size()), 0);
        issue_ready = 1'b0;

        // pc wrap on a 4-word memory with no last bit
        w_ready = 1'b1;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            while (!w_valid && cnt < 40) begin
                tick();
                cnt++;
            end
            check("t4_wrap_valid", 32'(w_valid), 1);
            check("t4_wrap_pc", 32'(w_pc), 32'(wrap_pc[k]));
            check("t4_wrap_op", 32'(w_opcode), 32'(wrap_op[k]));
            tick();
        end

        // Asynchronous reset in the middle of a pending handshake
        load_short();
        sb.push_back('{3'b000, 2'd0, 2'd0, 4'd0});
        pulse_start();
        wait_valid(cnt);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        wait_valid(cnt);
        check("t5_pre_pc", 32'(pc), 1);
        check("t5_pre_op", 32'(opcode), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(issue_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_pc", 32'(pc), 0);
        check("t5_rst_opcode", 32'(opcode), 0);
        check("t5_rst_wrap_valid", 32'(w_valid), 0);
        tick();
        rst_n = 1'b1;
        w_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_idle_busy", 32'(busy), 0);
            check("t5_idle_valid", 32'(issue_valid), 0);
        end
        check("t5_sb_empty", 32'(sb.size()), 0);

`ifdef SEQ_SINGLE_STEP_EN
        // Single-step: wait in PAUSE until step, then FETCH/WAIT/ISSUE
        step = 1'b0;
        load_short();
        sb.push_back('{3'b000, 2'd0, 2'd0, 4'd0});
        sb.push_back('{3'b001, 2'd1, 2'd1, 4'd1});
        sb.push_back('{3'b111, 2'd0, 2'd0, 4'd2});
        issue_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_valid(cnt);
            if (i > 0) check("t6_step_latency", 32'(cnt), 2);
            tick();
            if (i < 2) begin
                for (int k = 0; k < 4; k++) begin
                    check("t6_pause_busy", 32'(busy), 1);
                    check("t6_pause_valid", 32'(issue_valid), 0);
                    check("t6_pause_pc", 32'(pc), 32'(i + 1));
                    tick();
                end
                step = 1'b1;
                tick();
                step = 1'b0;
                check("t6_fetch_valid", 32'(issue_valid), 0);
            end else begin
                check("t6_done", 32'(done), 1);
            end
        end
        tick();
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_sb_empty", 32'(sb.size()), 0);
        issue_ready = 1'b0;
        step = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
